// File: rtl/uart_alu_pkg.sv
// Shared tags, state encoding and error codes for the UART-to-ALU controller.
package uart_alu_pkg;

   localparam logic [1:0] TAG_OPA = 2'b00;
   localparam logic [1:0] TAG_OPB = 2'b01;
   localparam logic [1:0] TAG_OP  = 2'b10;
   localparam logic [1:0] TAG_CMD = 2'b11;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      EXEC     = 2'd1,
      WAIT_ALU = 2'd2,
      SEND     = 2'd3
   } state_t;

   localparam logic [1:0] ERR_TIMEOUT    = 2'b01;
   localparam logic [1:0] ERR_OVERRUN    = 2'b10;
   localparam logic [1:0] ERR_INCOMPLETE = 2'b11;

   // Bits needed to hold a count of 0..max_val, never less than one.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/uart_alu_timeout.sv
// Reloadable saturating counter; o_expired flags the enabled cycle on which
// the count reaches LIMIT, so the caller can act on that same edge.
module uart_alu_timeout #(
   parameter int NB_CNT = 10,
   parameter int LIMIT  = 1000
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam logic [NB_CNT-1:0] LAST = NB_CNT'(LIMIT - 1);
   localparam logic [NB_CNT-1:0] SAT  = NB_CNT'(LIMIT);

   logic [NB_CNT-1:0] cnt;

   assign o_expired = i_enable && !i_clear && (cnt == LAST);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         cnt <= '0;
      end else if (i_clear) begin
         cnt <= '0;
      end else if (i_enable && (cnt != SAT)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_alu_ctrl.sv
// Decodes tagged UART words into ALU operands/opcode, launches the ALU and
// forwards the result to the UART transmitter, with timeout/overrun reporting.
module uart_alu_ctrl
   import uart_alu_pkg::*;
#(
   parameter int NB_DATA        = 8,
   parameter int NB_OP          = 6,
   parameter int NB_TAG         = 2,
   parameter int NB_FULL_DATA   = NB_TAG + NB_DATA,
   parameter int AUTO_EXEC      = 1,
   parameter int ALU_LATENCY    = 1,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int NB_TIMEOUT     = 10
) (
   input  logic                    i_clk,
   input  logic                    i_reset_n,
   input  logic [NB_FULL_DATA-1:0] i_rx_data,
   input  logic                    i_rx_valid,
   input  logic [NB_DATA-1:0]      i_alu_result,
   input  logic                    i_tx_busy,
   output logic [NB_DATA-1:0]      o_operand1,
   output logic [NB_DATA-1:0]      o_operand2,
   output logic [NB_OP-1:0]        o_opcode,
   output logic                    o_alu_valid,
   output logic [NB_DATA-1:0]      o_tx_data,
   output logic                    o_tx_start,
   output logic                    o_busy,
   output logic                    o_error,
   output logic [1:0]              o_err_code
);

   localparam int NB_LAT = cnt_width(ALU_LATENCY);

   state_t              state;
   logic                flag_a;
   logic                flag_b;
   logic                flag_op;
   logic [NB_TAG-1:0]   rx_tag;
   logic [NB_DATA-1:0]  rx_payload;
   logic                is_cmd;
   logic                all_next;
   logic                frame_active;
   logic                frame_expired;
   logic                lat_expired;

   assign rx_tag     = i_rx_data[NB_FULL_DATA-1 -: NB_TAG];
   assign rx_payload = i_rx_data[NB_DATA-1:0];
   assign is_cmd     = (rx_tag == TAG_CMD);

   // Flags as they would stand after the current word is decoded.
   assign all_next = (flag_a  || (rx_tag == TAG_OPA)) &&
                     (flag_b  || (rx_tag == TAG_OPB)) &&
                     (flag_op || (rx_tag == TAG_OP));

   assign frame_active = (AUTO_EXEC != 0) && (state == IDLE) && (flag_a || flag_b || flag_op);
   assign o_busy       = (state != IDLE);

   uart_alu_timeout #(
      .NB_CNT (NB_TIMEOUT),
      .LIMIT  (TIMEOUT_CYCLES)
   ) u_frame_timeout (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_clear   (i_rx_valid || !frame_active),
      .i_enable  (frame_active && !i_rx_valid),
      .o_expired (frame_expired)
   );

   uart_alu_timeout #(
      .NB_CNT (NB_LAT),
      .LIMIT  (ALU_LATENCY)
   ) u_alu_latency (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_clear   (state != WAIT_ALU),
      .i_enable  (state == WAIT_ALU),
      .o_expired (lat_expired)
   );

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state       <= IDLE;
         flag_a      <= 1'b0;
         flag_b      <= 1'b0;
         flag_op     <= 1'b0;
         o_operand1  <= '0;
         o_operand2  <= '0;
         o_opcode    <= '0;
         o_alu_valid <= 1'b0;
         o_tx_data   <= '0;
         o_tx_start  <= 1'b0;
         o_error     <= 1'b0;
         o_err_code  <= '0;
      end else begin
         o_alu_valid <= 1'b0;
         o_error     <= 1'b0;

         case (state)
            IDLE: begin
               if (i_rx_valid) begin
                  case (rx_tag)
                     TAG_OPA: begin
                        o_operand1 <= rx_payload;
                        flag_a     <= 1'b1;
                     end
                     TAG_OPB: begin
                        o_operand2 <= rx_payload;
                        flag_b     <= 1'b1;
                     end
                     TAG_OP: begin
                        o_opcode <= rx_payload[NB_OP-1:0];
                        flag_op  <= 1'b1;
                     end
                     default: begin
                        if (rx_payload[0]) begin
                           flag_a  <= 1'b0;
                           flag_b  <= 1'b0;
                           flag_op <= 1'b0;
                        end else if (AUTO_EXEC == 0) begin
                           // Manual mode keeps flags so operands can be reused.
                           if (flag_a && flag_b && flag_op) begin
                              state       <= EXEC;
                              o_alu_valid <= 1'b1;
                           end else begin
                              o_error    <= 1'b1;
                              o_err_code <= ERR_INCOMPLETE;
                           end
                        end
                     end
                  endcase

                  if ((AUTO_EXEC != 0) && !is_cmd && all_next) begin
                     state       <= EXEC;
                     o_alu_valid <= 1'b1;
                     flag_a      <= 1'b0;
                     flag_b      <= 1'b0;
                     flag_op     <= 1'b0;
                  end
               end else if (frame_expired) begin
                  flag_a     <= 1'b0;
                  flag_b     <= 1'b0;
                  flag_op    <= 1'b0;
                  o_error    <= 1'b1;
                  o_err_code <= ERR_TIMEOUT;
               end
            end

            EXEC: state <= WAIT_ALU;

            WAIT_ALU: begin
               if (lat_expired) begin
                  o_tx_data  <= i_alu_result;
                  o_tx_start <= !i_tx_busy;
                  state      <= SEND;
               end
            end

            SEND: begin
               // The start pulse is visible while still in SEND, then we leave.
               if (o_tx_start) begin
                  o_tx_start <= 1'b0;
                  state      <= IDLE;
               end else if (!i_tx_busy) begin
                  o_tx_start <= 1'b1;
               end
            end

            default: state <= IDLE;
         endcase

         if ((state != IDLE) && i_rx_valid) begin
            o_error    <= 1'b1;
            o_err_code <= ERR_OVERRUN;
         end
      end
   end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Self-checking bench: one auto-execute and one manual-execute controller,
// randomized frames checked against a behavioural model of the protocol.
module tb_uart_alu_ctrl;

   localparam int T     = 40;
   localparam int LAT_A = 1;
   localparam int LAT_M = 3;

   logic       clk;
   logic       reset_n;
   logic [9:0] rx_data;
   logic       rx_valid_a, rx_valid_m;
   logic       tx_busy;
   logic [7:0] alu_result_a, alu_result_m;

   logic [7:0] op1_a, op2_a, tx_data_a, op1_m, op2_m, tx_data_m;
   logic [5:0] opc_a, opc_m;
   logic       alu_valid_a, tx_start_a, busy_a, error_a;
   logic       alu_valid_m, tx_start_m, busy_m, error_m;
   logic [1:0] err_code_a, err_code_m;

   int tests_run = 0;
   int failures  = 0;

   // Model: the operand values each controller should currently present.
   logic [7:0] ma_a, ma_b, mm_a, mm_b;
   logic [5:0] ma_op, mm_op;
   int cd_a = 0;
   int cd_m = 0;

   uart_alu_ctrl #(
      .AUTO_EXEC(1), .ALU_LATENCY(LAT_A), .TIMEOUT_CYCLES(T), .NB_TIMEOUT(6)
   ) u_auto (
      .i_clk(clk), .i_reset_n(reset_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid_a),
      .i_alu_result(alu_result_a), .i_tx_busy(tx_busy),
      .o_operand1(op1_a), .o_operand2(op2_a), .o_opcode(opc_a), .o_alu_valid(alu_valid_a),
      .o_tx_data(tx_data_a), .o_tx_start(tx_start_a), .o_busy(busy_a),
      .o_error(error_a), .o_err_code(err_code_a)
   );

   uart_alu_ctrl #(
      .AUTO_EXEC(0), .ALU_LATENCY(LAT_M), .TIMEOUT_CYCLES(T), .NB_TIMEOUT(6)
   ) u_man (
      .i_clk(clk), .i_reset_n(reset_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid_m),
      .i_alu_result(alu_result_m), .i_tx_busy(tx_busy),
      .o_operand1(op1_m), .o_operand2(op2_m), .o_opcode(opc_m), .o_alu_valid(alu_valid_m),
      .o_tx_data(tx_data_m), .o_tx_start(tx_start_m), .o_busy(busy_m),
      .o_error(error_m), .o_err_code(err_code_m)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] alu_fn(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         6'h20:   return a + b;
         6'h22:   return a - b;
         6'h24:   return a & b;
         6'h25:   return a | b;
         default: return a ^ b;
      endcase
   endfunction

   // ALU stand-in: the correct result exists only in the cycle LAT after o_alu_valid.
   always @(posedge clk) begin
      #1;
      alu_result_a = (cd_a == 1) ? alu_fn(ma_op, ma_a, ma_b) : ~alu_fn(ma_op, ma_a, ma_b);
      if (cd_a > 0) cd_a--;
      if (alu_valid_a === 1'b1) cd_a = LAT_A;
      alu_result_m = (cd_m == 1) ? alu_fn(mm_op, mm_a, mm_b) : ~alu_fn(mm_op, mm_a, mm_b);
      if (cd_m > 0) cd_m--;
      if (alu_valid_m === 1'b1) cd_m = LAT_M;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input bit man, input logic [9:0] w);
      rx_data = w;
      if (man) rx_valid_m = 1'b1;
      else     rx_valid_a = 1'b1;
      tick();
      rx_valid_a = 1'b0;
      rx_valid_m = 1'b0;
   endtask

   // Called in the cycle right after the completing word: follows one execution to its tx pulse.
   task automatic expect_exec(input bit man, input string name);
      logic [7:0] ea, eb, er;
      logic [5:0] eo;
      int lat;
      bit bad;
      ea  = man ? mm_a : ma_a;
      eb  = man ? mm_b : ma_b;
      eo  = man ? mm_op : ma_op;
      er  = alu_fn(eo, ea, eb);
      lat = man ? LAT_M : LAT_A;
      tests_run++;
      if ((man ? alu_valid_m : alu_valid_a) !== 1'b1) begin
         failures++;
         $display("FAIL %s_alu_valid: got %b expected 1", name, man ? alu_valid_m : alu_valid_a);
      end
      tests_run++;
      if ((man ? {op1_m, op2_m, opc_m} : {op1_a, op2_a, opc_a}) !== {ea, eb, eo}) begin
         failures++;
         $display("FAIL %s_operands: got %h expected %h", name,
                  man ? {op1_m, op2_m, opc_m} : {op1_a, op2_a, opc_a}, {ea, eb, eo});
      end
      bad = 1'b0;
      for (int i = 0; i < lat; i++) begin
         tick();
         if ((man ? (alu_valid_m | tx_start_m) : (alu_valid_a | tx_start_a)) !== 1'b0) bad = 1'b1;
      end
      tests_run++;
      if (bad) begin
         failures++;
         $display("FAIL %s_quiet_wait: got a pulse during ALU wait, expected none", name);
      end
      tick();
      tests_run++;
      if ((man ? {tx_start_m, tx_data_m} : {tx_start_a, tx_data_a}) !== {1'b1, er}) begin
         failures++;
         $display("FAIL %s_tx: got start/data %h expected %h", name,
                  man ? {tx_start_m, tx_data_m} : {tx_start_a, tx_data_a}, {1'b1, er});
      end
      tick();
      tests_run++;
      if ((man ? {tx_start_m, busy_m} : {tx_start_a, busy_a}) !== 2'b00) begin
         failures++;
         $display("FAIL %s_back_idle: got start/busy %b expected 00", name,
                  man ? {tx_start_m, busy_m} : {tx_start_a, busy_a});
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; rx_data = '0; rx_valid_a = 1'b0; rx_valid_m = 1'b0; tx_busy = 1'b0;
      ma_a = '0; ma_b = '0; ma_op = '0; mm_a = '0; mm_b = '0; mm_op = '0;
      repeat (3) tick();
      tests_run++;
      if ({op1_a, op2_a, opc_a, alu_valid_a, tx_data_a, tx_start_a, busy_a, error_a, err_code_a} !== 36'h0) begin
         failures++;
         $display("FAIL reset_auto: got %h expected 0",
                  {op1_a, op2_a, opc_a, alu_valid_a, tx_data_a, tx_start_a, busy_a, error_a, err_code_a});
      end
      tests_run++;
      if ({op1_m, op2_m, opc_m, alu_valid_m, tx_data_m, tx_start_m, busy_m, error_m, err_code_m} !== 36'h0) begin
         failures++;
         $display("FAIL reset_manual: got %h expected 0",
                  {op1_m, op2_m, opc_m, alu_valid_m, tx_data_m, tx_start_m, busy_m, error_m, err_code_m});
      end
      @(negedge clk);
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_auto_basic();
      ma_a = 8'h05; ma_b = 8'h03; ma_op = 6'h20;
      send(0, 10'h005);
      send(0, 10'h103);
      tests_run++;
      if (alu_valid_a !== 1'b0) begin
         failures++;
         $display("FAIL basic_early_exec: got alu_valid %b expected 0", alu_valid_a);
      end
      send(0, 10'h220);
      expect_exec(0, "basic");
   endtask

   task automatic test_timeout();
      bit bad;
      ma_a = 8'h05;
      send(0, 10'h005);
      bad = 1'b0;
      repeat (T - 1) begin
         if (error_a !== 1'b0) bad = 1'b1;
         tick();
      end
      if (error_a !== 1'b0) bad = 1'b1;
      tests_run++;
      if (bad) begin
         failures++;
         $display("FAIL timeout_early: got error before %0d idle cycles, expected none", T);
      end
      tick();
      tests_run++;
      if ({error_a, err_code_a} !== 3'b101) begin
         failures++;
         $display("FAIL timeout_error: got error/code %b expected 101", {error_a, err_code_a});
      end
      tick();
      tests_run++;
      if ({error_a, err_code_a} !== 3'b001) begin
         failures++;
         $display("FAIL timeout_hold: got error/code %b expected 001", {error_a, err_code_a});
      end
      ma_b = 8'h03; ma_op = 6'h20;
      send(0, 10'h103);
      send(0, 10'h220);
      tests_run++;
      if ({alu_valid_a, busy_a} !== 2'b00) begin
         failures++;
         $display("FAIL timeout_flags_cleared: got valid/busy %b expected 00", {alu_valid_a, busy_a});
      end
      send(0, 10'h005);
      expect_exec(0, "after_timeout");
   endtask

   task automatic test_coincident();
      bit bad;
      ma_a = 8'($urandom); ma_b = 8'h03; ma_op = 6'h22;
      send(0, {2'b00, ma_a});
      bad = 1'b0;
      repeat (T - 1) begin
         if (error_a !== 1'b0) bad = 1'b1;
         tick();
      end
      send(0, 10'h103);
      if (error_a !== 1'b0) bad = 1'b1;
      repeat (T - 1) begin
         if (error_a !== 1'b0) bad = 1'b1;
         tick();
      end
      tests_run++;
      if (bad) begin
         failures++;
         $display("FAIL coincident_no_error: got an error pulse, expected none");
      end
      send(0, 10'h222);
      expect_exec(0, "coincident");
   endtask

   task automatic test_busy();
      bit bad;
      ma_a = 8'($urandom_range(0, 8'hA9)); ma_b = 8'($urandom); ma_op = 6'h24;
      tx_busy = 1'b1;
      send(0, {2'b00, ma_a});
      send(0, {2'b01, ma_b});
      send(0, {2'b10, 2'b11, ma_op});
      tests_run++;
      if (alu_valid_a !== 1'b1) begin
         failures++;
         $display("FAIL busy_exec: got alu_valid %b expected 1", alu_valid_a);
      end
      tick();
      bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (i == 5) begin
            send(0, 10'h0AA);
            tests_run++;
            if ({error_a, err_code_a, op1_a} !== {1'b1, 2'b10, ma_a}) begin
               failures++;
               $display("FAIL overrun: got error/code/opA %h expected %h",
                        {error_a, err_code_a, op1_a}, {1'b1, 2'b10, ma_a});
            end
         end else begin
            tick();
         end
         if ({tx_start_a, busy_a} !== 2'b01) bad = 1'b1;
      end
      tests_run++;
      if (bad) begin
         failures++;
         $display("FAIL busy_hold: got tx_start or idle while tx busy, expected hold in SEND");
      end
      tx_busy = 1'b0;
      tick();
      tests_run++;
      if ({tx_start_a, tx_data_a} !== {1'b1, alu_fn(ma_op, ma_a, ma_b)}) begin
         failures++;
         $display("FAIL busy_release_tx: got %h expected %h",
                  {tx_start_a, tx_data_a}, {1'b1, alu_fn(ma_op, ma_a, ma_b)});
      end
      tick();
      tests_run++;
      if ({tx_start_a, busy_a} !== 2'b00) begin
         failures++;
         $display("FAIL busy_back_idle: got %b expected 00", {tx_start_a, busy_a});
      end
   endtask

   task automatic test_clear();
      ma_a = 8'h11; ma_b = 8'h22; ma_op = 6'h25;
      send(0, 10'h011);
      send(0, 10'h122);
      send(0, 10'h301);
      send(0, 10'h225);
      tests_run++;
      if ({alu_valid_a, error_a} !== 2'b00) begin
         failures++;
         $display("FAIL clear_no_exec: got valid/error %b expected 00", {alu_valid_a, error_a});
      end
      send(0, 10'h011);
      send(0, 10'h122);
      expect_exec(0, "after_clear");
   endtask

   task automatic test_auto_random();
      logic [7:0] vals [3];
      logic [7:0] v;
      int order [3];
      int j, t;
      bit bad;
      for (int n = 0; n < 10; n++) begin
         vals[0] = 8'($urandom); vals[1] = 8'($urandom); vals[2] = 8'($urandom);
         ma_a = vals[0]; ma_b = vals[1]; ma_op = vals[2][5:0];
         order[0] = 0; order[1] = 1; order[2] = 2;
         for (int i = 2; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = order[i]; order[i] = order[j]; order[j] = t;
         end
         bad = 1'b0;
         if ($urandom_range(0, 1) == 1) begin
            v = 8'($urandom);
            send(0, {2'(order[0]), v});
            if (alu_valid_a !== 1'b0) bad = 1'b1;
         end
         for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(0, T - 2)) tick();
            if (k == 2 && $urandom_range(0, 1) == 1) begin
               v = 8'($urandom) & 8'hFE;
               send(0, {2'b11, v});
               if ({alu_valid_a, error_a} !== 2'b00) bad = 1'b1;
            end
            send(0, {2'(order[k]), vals[order[k]]});
            if (k < 2 && alu_valid_a !== 1'b0) bad = 1'b1;
         end
         tests_run++;
         if (bad) begin
            failures++;
            $display("FAIL random_partial_%0d: got early exec or error before frame complete", n);
         end
         expect_exec(0, "random");
      end
   endtask

   task automatic test_manual();
      logic [7:0] v;
      bit bad;
      mm_a = 8'h05; mm_b = 8'h03; mm_op = 6'h20;
      bad = 1'b0;
      send(1, 10'h005);
      if (alu_valid_m !== 1'b0) bad = 1'b1;
      send(1, 10'h103);
      if (alu_valid_m !== 1'b0) bad = 1'b1;
      send(1, 10'h220);
      if (alu_valid_m !== 1'b0) bad = 1'b1;
      tests_run++;
      if (bad) begin
         failures++;
         $display("FAIL manual_no_auto: got alu_valid without EXEC, expected none");
      end
      send(1, 10'h300);
      expect_exec(1, "manual_first");
      send(1, 10'h300);
      expect_exec(1, "manual_repeat");
      send(1, 10'h301);
      tests_run++;
      if ({alu_valid_m, error_m} !== 2'b00) begin
         failures++;
         $display("FAIL manual_clear: got valid/error %b expected 00", {alu_valid_m, error_m});
      end
      send(1, 10'h300);
      tests_run++;
      if ({alu_valid_m, error_m, err_code_m} !== 4'b0111) begin
         failures++;
         $display("FAIL manual_incomplete: got valid/error/code %b expected 0111",
                  {alu_valid_m, error_m, err_code_m});
      end
      mm_a = 8'($urandom); mm_b = 8'($urandom); v = 8'($urandom); mm_op = v[5:0];
      send(1, {2'b00, mm_a});
      send(1, {2'b01, mm_b});
      send(1, {2'b10, v});
      for (int n = 0; n < 6; n++) begin
         if ($urandom_range(0, 1) == 1) begin mm_a = 8'($urandom); send(1, {2'b00, mm_a}); end
         if ($urandom_range(0, 1) == 1) begin mm_b = 8'($urandom); send(1, {2'b01, mm_b}); end
         if ($urandom_range(0, 1) == 1) begin v = 8'($urandom); mm_op = v[5:0]; send(1, {2'b10, v}); end
         send(1, 10'h300);
         expect_exec(1, "manual_sticky");
      end
   endtask

   task automatic test_reset_mid();
      bit bad;
      send(1, 10'h300);
      tests_run++;
      if (alu_valid_m !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_exec: got alu_valid %b expected 1", alu_valid_m);
      end
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      tests_run++;
      if ({op1_m, op2_m, opc_m, alu_valid_m, tx_data_m, tx_start_m, busy_m, error_m, err_code_m} !== 36'h0) begin
         failures++;
         $display("FAIL reset_mid_async: got %h expected 0",
                  {op1_m, op2_m, opc_m, alu_valid_m, tx_data_m, tx_start_m, busy_m, error_m, err_code_m});
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      bad = 1'b0;
      repeat (LAT_M + 3) begin
         tick();
         if ({tx_start_m, alu_valid_m, busy_m} !== 3'b000) bad = 1'b1;
      end
      tests_run++;
      if (bad) begin
         failures++;
         $display("FAIL reset_mid_no_tx: got activity after reset, expected idle");
      end
      send(1, 10'h300);
      tests_run++;
      if ({alu_valid_m, error_m, err_code_m} !== 4'b0111) begin
         failures++;
         $display("FAIL reset_mid_flags: got valid/error/code %b expected 0111",
                  {alu_valid_m, error_m, err_code_m});
      end
   endtask

   initial begin
      test_reset();
      test_auto_basic();
      test_timeout();
      test_coincident();
      test_busy();
      test_clear();
      test_auto_random();
      test_manual();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

endmodule
